pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 14 +
 rtl/pipe_stage_reg_sat_counter.sv | 23 ++
 rtl/pipe_stage_reg.sv | 150 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: FSM states and default bundle widths.
package pipe_pkg;

  localparam int PIPE_CTRL_W    = 8;
  localparam int PIPE_PAYLOAD_W = 111;
  localparam int PIPE_CNT_W     = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts inc_i cycles and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, bubble-zeroed control and stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers In_Ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W    = PIPE_CTRL_W,
  parameter int PAYLOAD_W = PIPE_PAYLOAD_W,
  parameter int CNT_W     = PIPE_CNT_W
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [CTRL_W-1:0]    Ctrl_In,
  input  logic [PAYLOAD_W-1:0] Payload_In,
  input  logic                 Flush,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [CTRL_W-1:0]    Ctrl_Out,
  output logic [PAYLOAD_W-1:0] Payload_Out,
  output logic [CNT_W-1:0]     Stall_Cnt
);

  pipe_state_e            state_q;
  logic                   valid_q;
  logic [CTRL_W-1:0]      ctrl_q;
  logic [PAYLOAD_W-1:0]   payload_q;
  logic                   accept;

`ifdef PIPE_STAGE_SKID_EN
  logic                   in_ready_q;
  logic [CTRL_W-1:0]      skid_ctrl_q;
  logic [PAYLOAD_W-1:0]   skid_payload_q;

  assign In_Ready = in_ready_q;
  assign accept   = In_Valid && in_ready_q;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q        <= EMPTY;
      valid_q        <= 1'b0;
      in_ready_q     <= 1'b1;
      ctrl_q         <= '0;
      payload_q      <= '0;
      skid_ctrl_q    <= '0;
      skid_payload_q <= '0;
    end else if (Flush) begin
      state_q        <= EMPTY;
      valid_q        <= 1'b0;
      in_ready_q     <= 1'b1;
      ctrl_q         <= '0;
      skid_ctrl_q    <= '0;
      skid_payload_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q   <= FULL;
            valid_q   <= 1'b1;
            ctrl_q    <= Ctrl_In;
            payload_q <= Payload_In;
          end
        end
        FULL: begin
          if (accept && Out_Ready) begin
            ctrl_q    <= Ctrl_In;
            payload_q <= Payload_In;
          end else if (accept) begin
            // Downstream is stalled: park the new entry, close the input next cycle.
            state_q        <= SKID;
            in_ready_q     <= 1'b0;
            skid_ctrl_q    <= Ctrl_In;
            skid_payload_q <= Payload_In;
          end else if (Out_Ready) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
          end
        end
        SKID: begin
          if (Out_Ready) begin
            state_q        <= FULL;
            in_ready_q     <= 1'b1;
            ctrl_q         <= skid_ctrl_q;
            payload_q      <= skid_payload_q;
            skid_ctrl_q    <= '0;
            skid_payload_q <= '0;
          end
        end
        default: begin
          state_q    <= EMPTY;
          valid_q    <= 1'b0;
          in_ready_q <= 1'b1;
          ctrl_q     <= '0;
        end
      endcase
    end
  end
`else
  assign In_Ready = !valid_q || Out_Ready;
  assign accept   = In_Valid && In_Ready;

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q   <= EMPTY;
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      payload_q <= '0;
    end else if (Flush) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      case (state_q)
        EMPTY, FULL: begin
          if (accept) begin
            state_q   <= FULL;
            valid_q   <= 1'b1;
            ctrl_q    <= Ctrl_In;
            payload_q <= Payload_In;
          end else if (valid_q && Out_Ready) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          ctrl_q  <= '0;
        end
      endcase
    end
  end
`endif

  assign Out_Valid   = valid_q;
  assign Ctrl_Out    = ctrl_q;
  assign Payload_Out = payload_q;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .inc_i   (valid_q && !Out_Ready),
    .count_o (Stall_Cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle plus directed literals.
module tb_pipe_stage_reg;

  logic         CLOCK = 1'b0;
  logic         RESET;
  logic         In_Valid;
  logic [7:0]   Ctrl_In;
  logic [110:0] Payload_In;
  logic         Flush;
  logic         Out_Ready;

  logic         In_Ready, Out_Valid;
  logic [7:0]   Ctrl_Out;
  logic [110:0] Payload_Out;
  logic [15:0]  Stall_Cnt;

  logic         In_Ready4, Out_Valid4;
  logic [7:0]   Ctrl_Out4;
  logic [110:0] Payload_Out4;
  logic [3:0]   Stall_Cnt4;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK = ~CLOCK;

  pipe_stage_reg dut (
    .CLOCK(CLOCK), .RESET(RESET), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Ctrl_In(Ctrl_In), .Payload_In(Payload_In), .Flush(Flush),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Ctrl_Out(Ctrl_Out),
    .Payload_Out(Payload_Out), .Stall_Cnt(Stall_Cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut4 (
    .CLOCK(CLOCK), .RESET(RESET), .In_Valid(In_Valid), .In_Ready(In_Ready4),
    .Ctrl_In(Ctrl_In), .Payload_In(Payload_In), .Flush(Flush),
    .Out_Valid(Out_Valid4), .Out_Ready(Out_Ready), .Ctrl_Out(Ctrl_Out4),
    .Payload_Out(Payload_Out4), .Stall_Cnt(Stall_Cnt4)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 1 (2 with skid).
  typedef struct {
    logic [7:0]   c;
    logic [110:0] p;
  } ent_t;

  ent_t         mq[$];
  logic [110:0] m_last;
  int           m_stall;

  function automatic bit m_in_ready();
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || Out_Ready;
`endif
  endfunction

  always @(posedge CLOCK or posedge RESET) begin : model
    bit   ov;
    bit   ir;
    ent_t e;
    if (RESET) begin
      mq.delete();
      m_last  = '0;
      m_stall = 0;
    end else begin
      ov = mq.size() > 0;
      ir = m_in_ready();
      if (ov && !Out_Ready) m_stall++;
      if (Flush) begin
        mq.delete();
      end else begin
        if (ov && Out_Ready) void'(mq.pop_front());
        if (In_Valid && ir) begin
          e.c = Ctrl_In;
          e.p = Payload_In;
          mq.push_back(e);
        end
      end
      if (mq.size() > 0) m_last = mq[0].p;
    end
  end

  always @(negedge CLOCK) begin
    if (!RESET) begin
      chk("m_valid", Out_Valid, mq.size() > 0);
      chk("m_ctrl", Ctrl_Out, (mq.size() > 0) ? mq[0].c : 8'h00);
      chk("m_payload", Payload_Out, (mq.size() > 0) ? mq[0].p : m_last);
      chk("m_in_ready", In_Ready, m_in_ready());
      chk("m_stall", Stall_Cnt, (m_stall > 65535) ? 65535 : m_stall);
      chk("m_stall4", Stall_Cnt4, (m_stall > 15) ? 15 : m_stall);
      chk("m_valid4", Out_Valid4, mq.size() > 0);
      chk("m_ctrl4", Ctrl_Out4, (mq.size() > 0) ? mq[0].c : 8'h00);
    end
  end

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic rst_pulse();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [7:0] c, input logic [110:0] p, input logic ordy);
    In_Valid   = iv;
    Ctrl_In    = c;
    Payload_In = p;
    Out_Ready  = ordy;
  endtask

  localparam int NPAT = 8;
  logic [3:0]  pat_iv  = 4'b0;
  logic        pv[NPAT] = '{1, 1, 1, 0, 1, 1, 0, 0};
  logic [7:0]  pc[NPAT] = '{8'h01, 8'h02, 8'h03, 8'hEE, 8'h04, 8'h05, 8'hDD, 8'hCC};
  logic        pr[NPAT] = '{1, 0, 0, 1, 1, 1, 0, 1};

  initial begin
    RESET = 1'b1;
    Flush = 1'b0;
    drive(1'b0, 8'h00, '0, 1'b0);
    #12;
    RESET = 1'b0;
    chk("rst_valid", Out_Valid, 1'b0);
    chk("rst_ctrl", Ctrl_Out, 8'h00);
    chk("rst_payload", Payload_Out, 111'd0);
    chk("rst_stall", Stall_Cnt, 16'd0);
    chk("rst_in_ready", In_Ready, 1'b1);

    drive(1'b1, 8'hA5, 111'd5, 1'b1);
    cyc();
    chk("lat1_valid", Out_Valid, 1'b1);
    chk("lat1_ctrl", Ctrl_Out, 8'hA5);
    chk("lat1_payload", Payload_Out, 111'd5);

    // Hold for 3 cycles; Ctrl_In/Payload_In are garbage but In_Valid=0.
    drive(1'b0, 8'h77, 111'd123, 1'b0);
    repeat (3) cyc();
    chk("hold_valid", Out_Valid, 1'b1);
    chk("hold_ctrl", Ctrl_Out, 8'hA5);
    chk("hold_payload", Payload_Out, 111'd5);
    chk("hold_stall", Stall_Cnt, 16'd3);
`ifndef PIPE_STAGE_SKID_EN
    chk("hold_in_ready", In_Ready, 1'b0);
`endif

    Out_Ready = 1'b1;
    cyc();
    chk("retire_valid", Out_Valid, 1'b0);
    chk("retire_ctrl", Ctrl_Out, 8'h00);
    chk("retire_payload", Payload_Out, 111'd5);
    chk("retire_stall", Stall_Cnt, 16'd3);

    for (int i = 0; i < NPAT; i++) begin
      drive(pv[i], pc[i], 111'(16 * (i + 1)), pr[i]);
      cyc();
    end

    drive(1'b1, 8'h40, 111'd64, 1'b0);
    cyc();
    Flush = 1'b1;
    drive(1'b1, 8'hFF, 111'd99, 1'b0);
    cyc();
    Flush = 1'b0;
    chk("flush_valid", Out_Valid, 1'b0);
    chk("flush_ctrl", Ctrl_Out, 8'h00);
    drive(1'b0, 8'h00, '0, 1'b1);
    cyc();

`ifdef PIPE_STAGE_SKID_EN
    rst_pulse();
    drive(1'b1, 8'h11, 111'h111, 1'b0);
    cyc();
    drive(1'b1, 8'h22, 111'h222, 1'b0);
    cyc();
    chk("skid_in_ready", In_Ready, 1'b0);
    chk("skid_ctrl_a", Ctrl_Out, 8'h11);
    chk("skid_payload_a", Payload_Out, 111'h111);
    drive(1'b0, 8'h00, '0, 1'b1);
    cyc();
    chk("skid_ctrl_b", Ctrl_Out, 8'h22);
    chk("skid_payload_b", Payload_Out, 111'h222);
    chk("skid_in_ready_back", In_Ready, 1'b1);
    cyc();
    chk("skid_drained", Out_Valid, 1'b0);
`endif

    rst_pulse();
    drive(1'b1, 8'h33, 111'd7, 1'b0);
    cyc();
    In_Valid = 1'b0;
    repeat (20) cyc();
    chk("sat_stall16", Stall_Cnt, 16'd20);
    chk("sat_stall4", Stall_Cnt4, 4'd15);

    // Asynchronous reset between edges while FULL.
    #2;
    RESET = 1'b1;
    #1;
    chk("async_valid", Out_Valid, 1'b0);
    chk("async_ctrl", Ctrl_Out, 8'h00);
    chk("async_payload", Payload_Out, 111'd0);
    chk("async_stall", Stall_Cnt, 16'd0);
    #3;
    RESET = 1'b0;
    drive(1'b1, 8'h5A, 111'd42, 1'b1);
    cyc();
    chk("post_rst_valid", Out_Valid, 1'b1);
    chk("post_rst_ctrl", Ctrl_Out, 8'h5A);
    drive(1'b0, 8'h00, '0, 1'b1);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
